// File: rtl/pipe_pkg.sv
// Encodings shared by the ID/EX operand stage: forwarding selects, ALU operations,
// writeback selects and the packed control bundle that travels with each instruction.
package pipe_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  // An all-zero bundle is a bubble: no register write, no store, no redirect.
  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic [1:0] resultsrc;
    logic       alusrc;
  } ctrl_t;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Bundle of Decode inputs, hazard/bypass inputs and Execute outputs of the ID/EX stage.
interface id_ex_operand_stage_if #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5,
  parameter int ALUCTL_W  = 3
);

  logic                 flushE;
  logic                 stallE;
  logic [XLEN-1:0]      rd1D;
  logic [XLEN-1:0]      rd2D;
  logic [XLEN-1:0]      immextD;
  logic [XLEN-1:0]      pcD;
  logic [XLEN-1:0]      pcplus4D;
  logic [REGADDR_W-1:0] rs1D;
  logic [REGADDR_W-1:0] rs2D;
  logic [REGADDR_W-1:0] rdD;
  logic [ALUCTL_W-1:0]  alucontrolD;
  logic                 alusrcD;
  logic                 regwriteD;
  logic                 memwriteD;
  logic                 branchD;
  logic                 jumpD;
  logic [1:0]           resultsrcD;
  logic [1:0]           forwardaE;
  logic [1:0]           forwardbE;
  logic [XLEN-1:0]      aluoutM;
  logic [XLEN-1:0]      resultW;

  logic [XLEN-1:0]      srcaE;
  logic [XLEN-1:0]      srcbE;
  logic [ALUCTL_W-1:0]  alucontrolE;
  logic [XLEN-1:0]      writedataE;
  logic [XLEN-1:0]      pcE;
  logic [XLEN-1:0]      pcplus4E;
  logic [XLEN-1:0]      immextE;
  logic [REGADDR_W-1:0] rs1E;
  logic [REGADDR_W-1:0] rs2E;
  logic [REGADDR_W-1:0] rdE;
  logic                 regwriteE;
  logic                 memwriteE;
  logic                 branchE;
  logic                 jumpE;
  logic [1:0]           resultsrcE;
  logic                 validE;

  modport master (
    output flushE, stallE, rd1D, rd2D, immextD, pcD, pcplus4D, rs1D, rs2D, rdD,
           alucontrolD, alusrcD, regwriteD, memwriteD, branchD, jumpD, resultsrcD,
           forwardaE, forwardbE, aluoutM, resultW,
    input  srcaE, srcbE, alucontrolE, writedataE, pcE, pcplus4E, immextE,
           rs1E, rs2E, rdE, regwriteE, memwriteE, branchE, jumpE, resultsrcE, validE
  );

  modport slave (
    input  flushE, stallE, rd1D, rd2D, immextD, pcD, pcplus4D, rs1D, rs2D, rdD,
           alucontrolD, alusrcD, regwriteD, memwriteD, branchD, jumpD, resultsrcD,
           forwardaE, forwardbE, aluoutM, resultW,
    output srcaE, srcbE, alucontrolE, writedataE, pcE, pcplus4E, immextE,
           rs1E, rs2E, rdE, regwriteE, memwriteE, branchE, jumpE, resultsrcE, validE
  );

endinterface

// File: rtl/fwd_mux3.sv
// Operand bypass select: register-file value, Writeback result or Memory ALU result.
module fwd_mux3
  import pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_rf,
  input  logic [XLEN-1:0] i_wb,
  input  logic [XLEN-1:0] i_mem,
  input  logic [1:0]      i_sel,
  output logic [XLEN-1:0] o_y
);

  // The reserved code 2'b11 falls back to the register-file value.
  always_comb begin
    case (i_sel)
      FWD_WB:  o_y = i_wb;
      FWD_MEM: o_y = i_mem;
      default: o_y = i_rf;
    endcase
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with combinational operand forwarding and ALU-source select;
// flush loads a bubble and takes precedence over stall.
module id_ex_operand_stage
  import pipe_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5,
  parameter int ALUCTL_W  = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  id_ex_operand_stage_if.slave bus
);

  logic [XLEN-1:0]      r_rd1;
  logic [XLEN-1:0]      r_rd2;
  logic [XLEN-1:0]      r_immext;
  logic [XLEN-1:0]      r_pc;
  logic [XLEN-1:0]      r_pcplus4;
  logic [REGADDR_W-1:0] r_rs1;
  logic [REGADDR_W-1:0] r_rs2;
  logic [REGADDR_W-1:0] r_rd;
  logic [ALUCTL_W-1:0]  r_alucontrol;
  ctrl_t                r_ctrl;
  logic                 r_valid;

  logic [XLEN-1:0]      w_fwdA;
  logic [XLEN-1:0]      w_fwdB;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_immext     <= '0;
      r_pc         <= '0;
      r_pcplus4    <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_alucontrol <= '0;
      r_ctrl       <= '0;
      r_valid      <= 1'b0;
    end else if (bus.flushE) begin
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_immext     <= '0;
      r_pc         <= '0;
      r_pcplus4    <= '0;
      r_rs1        <= '0;
      r_rs2        <= '0;
      r_rd         <= '0;
      r_alucontrol <= '0;
      r_ctrl       <= '0;
      r_valid      <= 1'b0;
    end else if (!bus.stallE) begin
      r_rd1        <= bus.rd1D;
      r_rd2        <= bus.rd2D;
      r_immext     <= bus.immextD;
      r_pc         <= bus.pcD;
      r_pcplus4    <= bus.pcplus4D;
      r_rs1        <= bus.rs1D;
      r_rs2        <= bus.rs2D;
      r_rd         <= bus.rdD;
      r_alucontrol <= bus.alucontrolD;
      r_ctrl       <= '{regwrite:  bus.regwriteD,
                        memwrite:  bus.memwriteD,
                        branch:    bus.branchD,
                        jump:      bus.jumpD,
                        resultsrc: bus.resultsrcD,
                        alusrc:    bus.alusrcD};
      r_valid      <= 1'b1;
    end
  end

  // Bypass stays combinational so a stalled instruction keeps seeing live M/W values.
  fwd_mux3 #(.XLEN(XLEN)) u_fwd_a (
    .i_rf  (r_rd1),
    .i_wb  (bus.resultW),
    .i_mem (bus.aluoutM),
    .i_sel (bus.forwardaE),
    .o_y   (w_fwdA)
  );

  fwd_mux3 #(.XLEN(XLEN)) u_fwd_b (
    .i_rf  (r_rd2),
    .i_wb  (bus.resultW),
    .i_mem (bus.aluoutM),
    .i_sel (bus.forwardbE),
    .o_y   (w_fwdB)
  );

  assign bus.srcaE       = w_fwdA;
  assign bus.srcbE       = r_ctrl.alusrc ? r_immext : w_fwdB;
  assign bus.writedataE  = w_fwdB;
  assign bus.alucontrolE = r_alucontrol;
  assign bus.pcE         = r_pc;
  assign bus.pcplus4E    = r_pcplus4;
  assign bus.immextE     = r_immext;
  assign bus.rs1E        = r_rs1;
  assign bus.rs2E        = r_rs2;
  assign bus.rdE         = r_rd;
  assign bus.regwriteE   = r_ctrl.regwrite;
  assign bus.memwriteE   = r_ctrl.memwrite;
  assign bus.branchE     = r_ctrl.branch;
  assign bus.jumpE       = r_ctrl.jump;
  assign bus.resultsrcE  = r_ctrl.resultsrc;
  assign bus.validE      = r_valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: expected E-stage contents are queued when
// Decode inputs are driven and popped one edge later for comparison.
module tb_id_ex_operand_stage;
  import pipe_pkg::*;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int AW   = 3;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  alu;
    logic        alusrc;
    logic        regwrite;
    logic        memwrite;
    logic        branch;
    logic        jump;
    logic [1:0]  resultsrc;
    logic        valid;
  } ereg_t;

  logic  clk   = 1'b0;
  logic  rst_n = 1'b0;
  int    checks   = 0;
  int    failures = 0;
  ereg_t expQ[$];
  ereg_t model;

  always #5 clk = ~clk;

  id_ex_operand_stage_if #(.XLEN(XLEN), .REGADDR_W(RW), .ALUCTL_W(AW)) bus ();

  id_ex_operand_stage #(.XLEN(XLEN), .REGADDR_W(RW), .ALUCTL_W(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] fwdModel(input logic [1:0] sel, input logic [31:0] rf,
                                           input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'b01)      return wb;
    else if (sel == 2'b10) return mem;
    else                   return rf;
  endfunction

  function automatic ereg_t bubble();
    ereg_t r;
    r = '0;
    return r;
  endfunction

  function automatic ereg_t randInstr();
    ereg_t r;
    r.rd1       = $urandom;
    r.rd2       = $urandom;
    r.imm       = $urandom;
    r.pc        = $urandom & 32'hFFFF_FFFC;
    r.pcp4      = r.pc + 32'd4;
    r.rs1       = 5'($urandom);
    r.rs2       = 5'($urandom);
    r.rd        = 5'($urandom);
    r.alu       = 3'($urandom_range(0, 4));
    r.alusrc    = 1'($urandom);
    r.regwrite  = 1'($urandom);
    r.memwrite  = 1'($urandom);
    r.branch    = 1'($urandom);
    r.jump      = 1'($urandom);
    r.resultsrc = 2'($urandom_range(0, 2));
    r.valid     = 1'b1;
    return r;
  endfunction

  task automatic applyStimulus(input ereg_t d);
    bus.rd1D        = d.rd1;
    bus.rd2D        = d.rd2;
    bus.immextD     = d.imm;
    bus.pcD         = d.pc;
    bus.pcplus4D    = d.pcp4;
    bus.rs1D        = d.rs1;
    bus.rs2D        = d.rs2;
    bus.rdD         = d.rd;
    bus.alucontrolD = d.alu;
    bus.alusrcD     = d.alusrc;
    bus.regwriteD   = d.regwrite;
    bus.memwriteD   = d.memwrite;
    bus.branchD     = d.branch;
    bus.jumpD       = d.jump;
    bus.resultsrcD  = d.resultsrc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic popModel(input string name);
    checks++;
    if (expQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL %s scoreboard_empty got=0 entries want>=1", name);
    end else begin
      model = expQ.pop_front();
    end
  endtask

  task automatic test_reset();
    ereg_t d;
    bus.flushE = 1'b0; bus.stallE = 1'b0;
    bus.forwardaE = FWD_RF; bus.forwardbE = FWD_RF;
    bus.aluoutM = '0; bus.resultW = '0;
    applyStimulus(bubble());
    #12 rst_n = 1'b1;
    d = randInstr();
    d.regwrite = 1'b1; d.memwrite = 1'b1; d.branch = 1'b1; d.jump = 1'b1; d.alu = ALU_XOR;
    applyStimulus(d);
    expQ.push_back(d);
    tick();
    popModel("reset_preload");
    checks++;
    if ({bus.validE, bus.regwriteE, bus.memwriteE} !== 3'b111) begin
      failures++;
      $display("[TB] FAIL reset_preload got=%b want=111", {bus.validE, bus.regwriteE, bus.memwriteE});
    end
    #3 rst_n = 1'b0;
    #1;
    model = bubble();
    checks++;
    if ({bus.validE, bus.regwriteE, bus.memwriteE, bus.branchE, bus.jumpE, bus.alucontrolE, bus.resultsrcE} !== 10'd0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b want=0",
               {bus.validE, bus.regwriteE, bus.memwriteE, bus.branchE, bus.jumpE, bus.alucontrolE, bus.resultsrcE});
    end
    checks++;
    if ({bus.srcaE, bus.srcbE, bus.writedataE, bus.pcE, bus.pcplus4E, bus.immextE, bus.rs1E, bus.rs2E, bus.rdE} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data got srca=%h srcb=%h pc=%h rd=%h want all 0",
               bus.srcaE, bus.srcbE, bus.pcE, bus.rdE);
    end
    d = bubble();
    d.rd1 = 32'd5; d.rd2 = 32'd7; d.alu = ALU_ADD; d.regwrite = 1'b1; d.valid = 1'b1;
    applyStimulus(d);
    expQ.push_back(d);
    #2 rst_n = 1'b1;
    tick();
    popModel("reset_release");
    checks++;
    if ({bus.srcaE, bus.srcbE, bus.regwriteE, bus.validE} !== {32'd5, 32'd7, 1'b1, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset_release got srca=%0d srcb=%0d regwrite=%b valid=%b want 5 7 1 1",
               bus.srcaE, bus.srcbE, bus.regwriteE, bus.validE);
    end
  endtask

  task automatic test_imm_select();
    ereg_t d;
    d = randInstr();
    d.rd2 = 32'd7; d.imm = 32'hFFFF_FFFC; d.alusrc = 1'b1;
    applyStimulus(d);
    expQ.push_back(d);
    tick();
    popModel("imm_select");
    checks++;
    if (bus.srcbE !== 32'hFFFF_FFFC) begin
      failures++;
      $display("[TB] FAIL imm_srcb got=%h want=fffffffc", bus.srcbE);
    end
    checks++;
    if (bus.writedataE !== 32'd7) begin
      failures++;
      $display("[TB] FAIL imm_writedata got=%h want=00000007", bus.writedataE);
    end
  endtask

  task automatic test_forwarding();
    ereg_t d;
    logic [31:0] wantA [4];
    logic [31:0] wantB [4];
    wantA = '{32'd5, 32'h200, 32'h100, 32'd5};
    wantB = '{32'd7, 32'h200, 32'h100, 32'd7};
    d = randInstr();
    d.rd1 = 32'd5; d.rd2 = 32'd7; d.alusrc = 1'b0;
    applyStimulus(d);
    expQ.push_back(d);
    bus.aluoutM = 32'h100; bus.resultW = 32'h200;
    tick();
    popModel("forwarding");
    for (int i = 0; i < 4; i++) begin
      bus.forwardaE = 2'(i);
      bus.forwardbE = 2'(i);
      #1;
      checks++;
      if (bus.srcaE !== wantA[i]) begin
        failures++;
        $display("[TB] FAIL fwd_a sel=%0d got=%h want=%h", i, bus.srcaE, wantA[i]);
      end
      checks++;
      if (bus.srcbE !== wantB[i]) begin
        failures++;
        $display("[TB] FAIL fwd_b_srcb sel=%0d got=%h want=%h", i, bus.srcbE, wantB[i]);
      end
      checks++;
      if (bus.writedataE !== wantB[i]) begin
        failures++;
        $display("[TB] FAIL fwd_b_writedata sel=%0d got=%h want=%h", i, bus.writedataE, wantB[i]);
      end
    end
    bus.forwardaE = FWD_RF;
    bus.forwardbE = FWD_RF;
  endtask

  task automatic test_stall();
    ereg_t d;
    d = randInstr();
    d.alusrc = 1'b0;
    applyStimulus(d);
    expQ.push_back(d);
    tick();
    popModel("stall_load");
    bus.stallE = 1'b1;
    bus.forwardaE = FWD_MEM;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(randInstr());
      bus.aluoutM = $urandom;
      tick();
      checks++;
      if ({bus.pcE, bus.pcplus4E, bus.immextE, bus.rs1E, bus.rs2E, bus.rdE, bus.alucontrolE,
           bus.regwriteE, bus.memwriteE, bus.branchE, bus.jumpE, bus.resultsrcE, bus.validE} !==
          {model.pc, model.pcp4, model.imm, model.rs1, model.rs2, model.rd, model.alu,
           model.regwrite, model.memwrite, model.branch, model.jump, model.resultsrc, model.valid}) begin
        failures++;
        $display("[TB] FAIL stall_hold cycle=%0d got pc=%h rd=%h valid=%b want pc=%h rd=%h valid=%b",
                 i, bus.pcE, bus.rdE, bus.validE, model.pc, model.rd, model.valid);
      end
      checks++;
      if (bus.srcbE !== model.rd2) begin
        failures++;
        $display("[TB] FAIL stall_srcb cycle=%0d got=%h want=%h", i, bus.srcbE, model.rd2);
      end
      checks++;
      if (bus.srcaE !== bus.aluoutM) begin
        failures++;
        $display("[TB] FAIL stall_fwd_edge cycle=%0d got=%h want=%h", i, bus.srcaE, bus.aluoutM);
      end
      bus.aluoutM = $urandom;
      #1;
      checks++;
      if (bus.srcaE !== bus.aluoutM) begin
        failures++;
        $display("[TB] FAIL stall_fwd_mid cycle=%0d got=%h want=%h", i, bus.srcaE, bus.aluoutM);
      end
    end
    bus.stallE = 1'b0;
    bus.forwardaE = FWD_RF;
  endtask

  task automatic test_flush_vs_stall();
    ereg_t d;
    d = randInstr();
    d.regwrite = 1'b1; d.memwrite = 1'b1; d.branch = 1'b1; d.jump = 1'b1;
    d.alu = ALU_SUB; d.resultsrc = RES_PC4;
    applyStimulus(d);
    expQ.push_back(d);
    tick();
    popModel("flush_load");
    checks++;
    if ({bus.regwriteE, bus.memwriteE, bus.alucontrolE} !== {1'b1, 1'b1, 3'b001}) begin
      failures++;
      $display("[TB] FAIL flush_preload got=%b want=11001", {bus.regwriteE, bus.memwriteE, bus.alucontrolE});
    end
    bus.flushE = 1'b1;
    bus.stallE = 1'b1;
    d = randInstr();
    d.regwrite = 1'b1; d.memwrite = 1'b1;
    applyStimulus(d);
    expQ.push_back(bubble());
    tick();
    popModel("flush");
    checks++;
    if ({bus.validE, bus.regwriteE, bus.memwriteE, bus.branchE, bus.jumpE, bus.resultsrcE} !==
        {model.valid, model.regwrite, model.memwrite, model.branch, model.jump, model.resultsrc}) begin
      failures++;
      $display("[TB] FAIL flush_ctrl got=%b want=0",
               {bus.validE, bus.regwriteE, bus.memwriteE, bus.branchE, bus.jumpE, bus.resultsrcE});
    end
    checks++;
    if (bus.alucontrolE !== 3'b000) begin
      failures++;
      $display("[TB] FAIL flush_alucontrol got=%b want=000", bus.alucontrolE);
    end
    checks++;
    if ({bus.srcaE, bus.srcbE, bus.pcE, bus.rdE} !== '0) begin
      failures++;
      $display("[TB] FAIL flush_data got srca=%h srcb=%h pc=%h rd=%h want all 0",
               bus.srcaE, bus.srcbE, bus.pcE, bus.rdE);
    end
    bus.flushE = 1'b0;
    bus.stallE = 1'b0;
  endtask

  task automatic test_back_to_back();
    ereg_t d;
    logic [31:0] wantB;
    for (int i = 0; i < 4; i++) begin
      d = randInstr();
      applyStimulus(d);
      expQ.push_back(d);
      tick();
      popModel("back_to_back");
      checks++;
      if ({bus.pcE, bus.pcplus4E, bus.immextE, bus.rs1E, bus.rs2E, bus.rdE, bus.alucontrolE,
           bus.regwriteE, bus.memwriteE, bus.branchE, bus.jumpE, bus.resultsrcE, bus.validE} !==
          {model.pc, model.pcp4, model.imm, model.rs1, model.rs2, model.rd, model.alu,
           model.regwrite, model.memwrite, model.branch, model.jump, model.resultsrc, model.valid}) begin
        failures++;
        $display("[TB] FAIL b2b_regs instr=%0d got pc=%h imm=%h rs1=%h rs2=%h rd=%h alu=%b ctl=%b want pc=%h imm=%h rs1=%h rs2=%h rd=%h alu=%b ctl=%b",
                 i, bus.pcE, bus.immextE, bus.rs1E, bus.rs2E, bus.rdE, bus.alucontrolE,
                 {bus.regwriteE, bus.memwriteE, bus.branchE, bus.jumpE, bus.resultsrcE, bus.validE},
                 model.pc, model.imm, model.rs1, model.rs2, model.rd, model.alu,
                 {model.regwrite, model.memwrite, model.branch, model.jump, model.resultsrc, model.valid});
      end
      checks++;
      if (bus.srcaE !== fwdModel(FWD_RF, model.rd1, bus.resultW, bus.aluoutM)) begin
        failures++;
        $display("[TB] FAIL b2b_srca instr=%0d got=%h want=%h", i, bus.srcaE, model.rd1);
      end
      wantB = model.alusrc ? model.imm : model.rd2;
      checks++;
      if (bus.srcbE !== wantB) begin
        failures++;
        $display("[TB] FAIL b2b_srcb instr=%0d got=%h want=%h", i, bus.srcbE, wantB);
      end
      checks++;
      if (bus.writedataE !== model.rd2) begin
        failures++;
        $display("[TB] FAIL b2b_writedata instr=%0d got=%h want=%h", i, bus.writedataE, model.rd2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_imm_select();
    test_forwarding();
    test_stall();
    test_flush_vs_stall();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
